// File: rtl/mini_control_fsm.sv
// Multi-cycle control sequencer for the RV32I mini core: fetch, decode check, execute,
// shift wait, write-back and next-PC update, with a sticky halt on bad encodings or targets.
module mini_control_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             resetn,
  output logic [31:0]      mem_addr,
  output logic             mem_rstrb,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_rbusy,
  output logic [31:0]      instr,
  output logic [31:0]      pc,
  input  logic [31:0]      imm,
  input  logic [31:0]      alu_out,
  input  logic             alu_cond,
  input  logic             alu_busy,
  output logic             alu_start,
  output logic             wb_en,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic             illegal,
  output logic             misaligned,
  output logic [CNT_W-1:0] instret
);

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  localparam logic [4:0] OpAluReg = 5'b01100;
  localparam logic [4:0] OpAluImm = 5'b00100;
  localparam logic [4:0] OpLui    = 5'b01101;
  localparam logic [4:0] OpAuipc  = 5'b00101;
  localparam logic [4:0] OpJal    = 5'b11011;
  localparam logic [4:0] OpJalr   = 5'b11001;
  localparam logic [4:0] OpBranch = 5'b11000;

  typedef enum logic [2:0] {
    StFetchReq,
    StFetchWait,
    StDecode,
    StExecute,
    StWaitAlu,
    StWriteback,
    StHalt
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic             misaligned_q, misaligned_d;
  logic             mem_rstrb_q, mem_rstrb_d;
  logic             alu_start_q, alu_start_d;
  logic             wb_en_q, wb_en_d;
  logic [1:0]       wb_sel_q, wb_sel_d;
  logic             halted_q, halted_d;

  logic [4:0]  opcode;
  logic [2:0]  func3;
  logic        is_alu, is_jal, is_jalr, is_branch, is_lui, is_auipc;
  logic        legal, uses_alu, is_shift, writes_rd;
  logic [1:0]  sel_code;
  logic [31:0] pc_plus4, pc_plus_imm, next_pc;

  // Instruction classification from the latched word
  always_comb begin
    opcode    = instr_q[6:2];
    func3     = instr_q[14:12];
    is_alu    = (opcode == OpAluReg) || (opcode == OpAluImm);
    is_lui    = (opcode == OpLui);
    is_auipc  = (opcode == OpAuipc);
    is_jal    = (opcode == OpJal);
    is_jalr   = (opcode == OpJalr);
    is_branch = (opcode == OpBranch);
    legal     = (instr_q[1:0] == 2'b11) &&
                (is_alu || is_lui || is_auipc || is_jal || is_jalr || is_branch);
    uses_alu  = is_alu || is_jalr || is_branch;
    is_shift  = is_alu && ((func3 == 3'b001) || (func3 == 3'b101));
    writes_rd = legal && !is_branch && (instr_q[11:7] != 5'd0);

    if (is_lui) begin
      sel_code = 2'd1;
    end else if (is_jal || is_jalr) begin
      sel_code = 2'd2;
    end else if (is_auipc) begin
      sel_code = 2'd3;
    end else begin
      sel_code = 2'd0;
    end

    pc_plus4    = pc_q + 32'd4;
    pc_plus_imm = pc_q + imm;
    if (is_jal) begin
      next_pc = pc_plus_imm;
    end else if (is_jalr) begin
      next_pc = alu_out & 32'hFFFF_FFFE;
    end else if (is_branch) begin
      next_pc = alu_cond ? pc_plus_imm : pc_plus4;
    end else begin
      next_pc = pc_plus4;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instret_d    = instret_q;
    illegal_d    = illegal_q;
    misaligned_d = misaligned_q;

    unique case (state_q)
      // The first cycle after reset raises the strobe; we leave once it has been seen.
      StFetchReq: begin
        if (mem_rstrb_q) state_d = StFetchWait;
      end
      StFetchWait: begin
        if (!mem_rbusy) begin
          instr_d = mem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (legal) begin
          state_d = StExecute;
        end else begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end
      end
      StExecute: begin
        state_d = is_shift ? StWaitAlu : StWriteback;
      end
      StWaitAlu: begin
        if (!alu_busy) state_d = StWriteback;
      end
      StWriteback: begin
        if (next_pc[1]) begin
          misaligned_d = 1'b1;
          state_d      = StHalt;
        end else begin
          pc_d      = next_pc;
          instret_d = instret_q + CNT_W'(1);
          state_d   = StFetchReq;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StHalt;
      end
    endcase

    // Strobes are registered off the upcoming state so each lasts exactly one cycle.
    mem_rstrb_d = (state_d == StFetchReq);
    alu_start_d = (state_d == StExecute) && uses_alu;
    wb_en_d     = (state_d == StWriteback) && writes_rd;
    wb_sel_d    = (state_d == StWriteback) ? sel_code : 2'd0;
    halted_d    = (state_d == StHalt);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StFetchReq;
      pc_q         <= RESET_PC;
      instr_q      <= NopInstr;
      instret_q    <= '0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
      mem_rstrb_q  <= 1'b0;
      alu_start_q  <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_sel_q     <= 2'd0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instret_q    <= instret_d;
      illegal_q    <= illegal_d;
      misaligned_q <= misaligned_d;
      mem_rstrb_q  <= mem_rstrb_d;
      alu_start_q  <= alu_start_d;
      wb_en_q      <= wb_en_d;
      wb_sel_q     <= wb_sel_d;
      halted_q     <= halted_d;
    end
  end

  assign mem_addr   = pc_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign instret    = instret_q;
  assign illegal    = illegal_q;
  assign misaligned = misaligned_q;
  assign mem_rstrb  = mem_rstrb_q;
  assign alu_start  = alu_start_q;
  assign wb_en      = wb_en_q;
  assign wb_sel     = wb_sel_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_mini_control_fsm.sv
// Directed bench for mini_control_fsm: walks a short instruction stream cycle by cycle and
// checks strobes, write-back, PC, counters and the halt paths against hand-computed values.
module tb_mini_control_fsm;

  localparam logic [31:0] Addi = 32'h0050_0093;
  localparam logic [31:0] Slli = 32'h0030_9113;
  localparam logic [31:0] Nop  = 32'h0000_0013;
  localparam logic [31:0] Jal  = 32'h0080_00EF;
  localparam logic [31:0] Beq  = 32'h0000_0863;
  localparam logic [31:0] Jalr = 32'h0000_80E7;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] mem_addr, mem_rdata, instr, pc, imm, alu_out, instret;
  logic        mem_rstrb, mem_rbusy, alu_cond, alu_busy, alu_start, wb_en;
  logic [1:0]  wb_sel;
  logic        halted, illegal, misaligned;

  int n_pass = 0;
  int n_total = 0;
  int rstrb_cnt = 0;
  int wb_cnt = 0;
  int start_cnt = 0;
  int base_r, base_w;

  mini_control_fsm #(
    .RESET_PC(32'h0000_0000),
    .CNT_W   (32)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_addr  (mem_addr),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .mem_rbusy (mem_rbusy),
    .instr     (instr),
    .pc        (pc),
    .imm       (imm),
    .alu_out   (alu_out),
    .alu_cond  (alu_cond),
    .alu_busy  (alu_busy),
    .alu_start (alu_start),
    .wb_en     (wb_en),
    .wb_sel    (wb_sel),
    .halted    (halted),
    .illegal   (illegal),
    .misaligned(misaligned),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rstrb) rstrb_cnt <= rstrb_cnt + 1;
    if (wb_en)     wb_cnt    <= wb_cnt + 1;
    if (alu_start) start_cnt <= start_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  initial begin
    resetn = 1'b0; mem_rdata = '0; mem_rbusy = 1'b0; imm = '0; alu_out = '0;
    alu_cond = 1'b0; alu_busy = 1'b0;
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_instr", instr, Nop);
    chk("rst_rstrb", mem_rstrb, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_sel", wb_sel, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_misal", misaligned, 0);
    chk("rst_instret", instret, 0);

    // ADDI with two busy memory cycles
    mem_rdata = Addi; mem_rbusy = 1'b1; alu_out = 32'd5; resetn = 1'b1;
    step(); chk("addi_rstrb", mem_rstrb, 1); chk("addi_addr", mem_addr, 32'h0);
    step(); chk("addi_rstrb_once", mem_rstrb, 0);
    step();
    step(); mem_rbusy = 1'b0;
    step(); chk("addi_instr", instr, Addi);
    step(); chk("addi_start", alu_start, 1);
    step(); chk("addi_wb_en", wb_en, 1); chk("addi_wb_sel", wb_sel, 0);
    chk("addi_no_rstrb", mem_rstrb, 0);
    step(); chk("addi_pc", pc, 32'h4); chk("addi_instret", instret, 1);
    chk("addi_next_rstrb", mem_rstrb, 1); chk("addi_rstrb_cnt", rstrb_cnt, 1);
    chk("addi_wb_cnt", wb_cnt, 1);

    // SLLI with alu_busy for three cycles after the start pulse
    mem_rdata = Slli; alu_out = 32'd40;
    step(); step();
    step(); chk("slli_start", alu_start, 1); alu_busy = 1'b1;
    step(); chk("slli_wait1", wb_en, 0);
    step(); chk("slli_wait2", wb_en, 0);
    step(); chk("slli_wait3", wb_en, 0); alu_busy = 1'b0;
    step(); chk("slli_wb_en", wb_en, 1); chk("slli_wb_sel", wb_sel, 0);
    step(); chk("slli_pc", pc, 32'h8); chk("slli_instret", instret, 2);
    chk("slli_start_cnt", start_cnt, 2);

    // Two NOPs (rd=x0) to reach 0x10
    mem_rdata = Nop;
    repeat (10) step();
    chk("nop_pc", pc, 32'h10); chk("nop_wb_cnt", wb_cnt, 2); chk("nop_instret", instret, 4);

    // JAL x1,+8
    mem_rdata = Jal; imm = 32'd8;
    step(); step();
    step(); chk("jal_no_start", alu_start, 0);
    step(); chk("jal_wb_en", wb_en, 1); chk("jal_wb_sel", wb_sel, 2);
    step(); chk("jal_pc", pc, 32'h18); chk("jal_instret", instret, 5);

    mem_rdata = Nop;
    repeat (10) step();
    chk("nop2_pc", pc, 32'h20);

    // BEQ taken, taken backwards (wraps), then not taken
    mem_rdata = Beq; imm = 32'd16; alu_cond = 1'b1;
    step(); step();
    step(); chk("beq_start", alu_start, 1);
    step(); chk("beq_no_wb", wb_en, 0);
    step(); chk("beq_taken_pc", pc, 32'h30); chk("beq_instret", instret, 8);
    imm = 32'hFFFF_FFF0;
    repeat (5) step();
    chk("beq_back_pc", pc, 32'h20);
    alu_cond = 1'b0; imm = 32'd16;
    repeat (5) step();
    chk("beq_nt_pc", pc, 32'h24); chk("beq_nt_instret", instret, 10);
    chk("beq_wb_cnt", wb_cnt, 3);

    // JALR to a misaligned target
    mem_rdata = Jalr; alu_out = 32'h0000_0102; imm = '0;
    step(); step();
    step(); chk("jalr_start", alu_start, 1);
    step(); chk("jalr_wb_en", wb_en, 1); chk("jalr_wb_sel", wb_sel, 2);
    step(); chk("jalr_halted", halted, 1); chk("jalr_misal", misaligned, 1);
    chk("jalr_illegal", illegal, 0); chk("jalr_pc", pc, 32'h24);
    chk("jalr_instret", instret, 10);
    base_r = rstrb_cnt;
    repeat (4) step();
    chk("jalr_no_fetch", rstrb_cnt, base_r); chk("jalr_still_halted", halted, 1);

    // Illegal all-zero word after a fresh reset
    resetn = 1'b0;
    step(); chk("rst2_halted", halted, 0); chk("rst2_misal", misaligned, 0);
    mem_rdata = 32'h0; resetn = 1'b1;
    base_r = rstrb_cnt; base_w = wb_cnt;
    step(); step(); step(); step();
    chk("ill_illegal", illegal, 1); chk("ill_halted", halted, 1);
    chk("ill_pc", pc, 32'h0); chk("ill_instret", instret, 0); chk("ill_instr", instr, 32'h0);
    repeat (4) step();
    chk("ill_one_fetch", rstrb_cnt, base_r + 1); chk("ill_no_wb", wb_cnt, base_w);

    // Reset asserted while waiting on a shift
    resetn = 1'b0;
    step(); mem_rdata = Addi; resetn = 1'b1;
    repeat (6) step();
    chk("ra_pc", pc, 32'h4);
    mem_rdata = Slli; alu_busy = 1'b1; base_w = wb_cnt;
    repeat (4) step();
    chk("ra_wait_no_wb", wb_en, 0);
    #2 resetn = 1'b0;
    #1;
    chk("ra_pc_rst", pc, 32'h0); chk("ra_addr_rst", mem_addr, 32'h0);
    chk("ra_instr_rst", instr, Nop); chk("ra_instret_rst", instret, 0);
    chk("ra_start_rst", alu_start, 0); chk("ra_rstrb_rst", mem_rstrb, 0);
    step(); step();
    chk("ra_no_wb", wb_cnt, base_w);
    alu_busy = 1'b0; mem_rdata = Addi; resetn = 1'b1;
    step(); chk("ra_refetch", mem_rstrb, 1); chk("ra_refetch_addr", mem_addr, 32'h0);
    repeat (5) step();
    chk("ra_pc_after", pc, 32'h4); chk("ra_instret_after", instret, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
